// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding a UART TX FIFO push port.
// Each granted packet is optionally prefixed with a sync byte and the
// requester id, then the payload is passed through with zero latency.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | no packet owner; one-cycle grant decision when any valid
// HDR_SYNC | pushing SYNC_BYTE (waits while FIFO full)
// HDR_ID   | pushing zero-extended grant_id (waits while FIFO full)
// PAYLOAD  | pass-through of granted requester until its last byte
module uart_tx_arbiter #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_REQ    = 4,
    parameter int                    HEADER_EN  = 1,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_last,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [DATA_WIDTH-1:0]                tx_data,
    output logic                                 push,
    input  logic                                 tx_fifo_full,
    output logic [3:0]                           grant_id,
    output logic                                 busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_SYNC = 2'd1,
        HDR_ID   = 2'd2,
        PAYLOAD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      grant_id_q, grant_id_d;
    logic [3:0]      last_grant_q, last_grant_d;

    logic [3:0]            arb_pick;
    logic                  arb_found;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    // Round-robin search: indices above last_grant first, then wrap to the low ones
    always_comb begin
        arb_pick  = 4'd0;
        arb_found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!arb_found && req_valid[j] && (4'(j) > last_grant_q)) begin
                arb_found = 1'b1;
                arb_pick  = 4'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!arb_found && req_valid[j] && (4'(j) <= last_grant_q)) begin
                arb_found = 1'b1;
                arb_pick  = 4'(j);
            end
        end
    end

    // Select the granted requester's payload signals
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id_q == 4'(j)) begin
                sel_valid = req_valid[j];
                sel_last  = req_last[j];
                sel_data  = req_data[j];
            end
        end
    end

    // Next-state and output decode; reset gates outputs so an abandoned
    // packet gets no further push even in the cycle reset is first seen
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        push         = 1'b0;
        tx_data      = '0;
        req_ready    = '0;
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_id_d = arb_pick;
                    state_d    = (HEADER_EN != 0) ? HDR_SYNC : PAYLOAD;
                end
            end
            HDR_SYNC: begin
                if (!tx_fifo_full) begin
                    push    = 1'b1;
                    tx_data = SYNC_BYTE;
                    state_d = HDR_ID;
                end
            end
            HDR_ID: begin
                if (!tx_fifo_full) begin
                    push    = 1'b1;
                    tx_data = DATA_WIDTH'(grant_id_q);
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    req_ready[j] = (grant_id_q == 4'(j)) && !tx_fifo_full;
                end
                if (sel_valid && !tx_fifo_full) begin
                    push    = 1'b1;
                    tx_data = sel_data;
                    if (sel_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_id_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            push      = 1'b0;
            tx_data   = '0;
            req_ready = '0;
            busy      = 1'b0;
        end
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_id_q   <= 4'd0;
            last_grant_q <= 4'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_id = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: byte width of every data path.
REQ-002 Parameter NUM_REQ, default 4: number of requester ports, legal range 2..16.
REQ-003 Parameter HEADER_EN, default 1: 1 prefixes each packet with a 2-byte header; 0 sends payload only.
REQ-004 Parameter SYNC_BYTE, default 8'hA5: first header byte.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_data  input  NUM_REQ x DATA_WIDTH  per-requester payload byte.
REQ-008 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-009 req_last  input  NUM_REQ  marks final byte of a packet; qualified by req_valid.
REQ-010 req_ready  output  NUM_REQ  per-requester byte accept.
REQ-011 tx_data  output  DATA_WIDTH  byte to the UART TX FIFO push port.
REQ-012 push  output  1  one-cycle write strobe to the UART TX FIFO.
REQ-013 tx_fifo_full  input  1  UART TX FIFO full flag.
REQ-014 grant_id  output  4  index of the requester currently owning the link.
REQ-015 busy  output  1  high while a packet is in progress.

Function
REQ-016 The FSM SHALL have states IDLE, HDR_SYNC, HDR_ID and PAYLOAD.
REQ-017 Arbitration SHALL be packet-granular round-robin: in IDLE, with any req_valid high, grant the first valid index searching upward (with wrap) from last_grant+1.
REQ-018 last_grant SHALL reset to NUM_REQ-1, so requester 0 wins the first tie.
REQ-019 The grant decision SHALL take one cycle in IDLE, register grant_id, then go to HDR_SYNC (HEADER_EN=1) or PAYLOAD (HEADER_EN=0).
REQ-020 HDR_SYNC SHALL push SYNC_BYTE when tx_fifo_full=0, then go to HDR_ID; if full, it holds with push=0.
REQ-021 HDR_ID SHALL push grant_id zero-extended to DATA_WIDTH when tx_fifo_full=0, then go to PAYLOAD.
REQ-022 In PAYLOAD: req_ready[grant_id] = ~tx_fifo_full; all other req_ready bits SHALL be 0.
REQ-023 In PAYLOAD, push SHALL equal req_valid[grant_id] & ~tx_fifo_full, with tx_data = req_data[grant_id] in the same cycle (zero-latency pass-through).
REQ-024 Accepting a byte with req_last[grant_id]=1 SHALL return the FSM to IDLE and set last_grant to grant_id.
REQ-025 push SHALL never assert while tx_fifo_full=1 in any state.
REQ-026 The grant SHALL be held until the last byte, regardless of the granted requester's valid gaps or other requesters' activity; there is no timeout.
REQ-027 req_ready SHALL be 0 in IDLE, HDR_SYNC and HDR_ID.
REQ-028 busy SHALL be high in every state except IDLE.
REQ-029 tx_data SHALL be 0 whenever push=0.
REQ-030 A single-byte packet (valid and last together) SHALL be legal and produce header plus one payload byte.
REQ-031 A requester deasserting valid mid-packet SHALL NOT lose ownership; the arbiter waits in PAYLOAD.
REQ-032 Back-to-back packets SHALL incur exactly one IDLE cycle between the last payload push and the next SYNC push when the FIFO is not full.

Reset
REQ-033 Reset SHALL force: state=IDLE, grant_id=0, last_grant=NUM_REQ-1, push=0, tx_data=0, req_ready=0, busy=0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet immediately with no further push; the next packet starts cleanly with a header.

Verification
REQ-035 Single packet: req 2 sends 8'h11, 8'h22 (last), FIFO never full -> push sequence A5, 02, 11, 22; busy high 4 cycles after grant; one IDLE cycle before and after.
REQ-036 Fairness: reqs 0, 1, 3 each hold a 1-byte packet continuously -> ID bytes in order 00, 01, 03, 00, 01, 03.
REQ-037 Backpressure: tx_fifo_full=1 for 5 cycles during HDR_ID and during PAYLOAD -> no push while full, no byte lost or duplicated, req_ready=0 during full.
REQ-038 Valid gap: granted req 1 drops valid for 3 cycles mid-packet while req 0 is valid -> grant stays 1, no push during the gap, req 0 granted only after req 1's last byte.
REQ-039 Reset mid-PAYLOAD after 2 of 4 bytes -> push=0 the next cycle, all outputs at reset values, next packet begins with A5.
REQ-040 HEADER_EN=0: req 0 sends 3 bytes -> exactly 3 pushes, no A5 or ID byte.
